dac_serial_stream: RTL and testbench
====================================

DAC_SERIAL_STREAM -- requirements
Module: dac_serial_stream

Interface
REQ-001 Parameter DW, default 16, sample width per channel in bits (>=2).
REQ-002 Parameter NCH, default 2, channel count (>=1); channels share sclk and cs_n, each has its own sdi line.
REQ-003 Parameter CLK_DIV, default 1, sclk half-period in fclk cycles (>=1).
REQ-004 Parameter FRAME_CYC, default 24, frame length in sclk periods (>DW).
REQ-005 fclk  input  1  clock; all logic single-domain on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  run enable; frames start only while high.
REQ-008 s_axis_tvalid  input  1  sample vector valid.
REQ-009 s_axis_tready  output  1  sample accepted this cycle when high with tvalid.
REQ-010 s_axis_tdata  input  NCH*DW  channel k sample at bits [k*DW +: DW].
REQ-011 sclk  output  1  serial clock to all DACs.
REQ-012 sdi  output  NCH  serial data; sdi[k] drives channel k.
REQ-013 cs_n  output  1  shared chip select; rising edge latches DACs.
REQ-014 frame_done  output  1  one-cycle pulse on each cs_n rise.
REQ-015 underrun  output  1  one-cycle pulse when a frame starts without valid data.

Function
REQ-016 States: IDLE, LOAD, SHIFT, GAP.
REQ-017 IDLE: cs_n=1, sclk=0, tready=0; go to LOAD on the cycle after en is sampled high.
REQ-018 LOAD lasts exactly one fclk cycle; s_axis_tready=1 only in LOAD.
REQ-019 LOAD with tvalid=1: capture s_axis_tdata into per-channel shift registers and the held sample.
REQ-020 LOAD with tvalid=0: reload the held sample (zero after reset) and pulse underrun in the same cycle.
REQ-021 cs_n goes 0 on the first SHIFT cycle; sdi[k] presents bit DW-1 (MSB first) of channel k from that cycle.
REQ-022 SHIFT: each bit period is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1; sdi changes only on sclk falling (start of the next bit period); exactly DW rising sclk edges per frame.
REQ-023 After the last high phase, sclk=0 and cs_n=1 in the same cycle; frame_done pulses in that cycle; enter GAP.
REQ-024 GAP lasts (FRAME_CYC-DW)*2*CLK_DIV-1 cycles with cs_n=1 and sclk=0; then LOAD if en=1, else IDLE.
REQ-025 While en stays high, frame period is exactly FRAME_CYC*2*CLK_DIV fclk cycles (48 at defaults), LOAD to LOAD.
REQ-026 en falling mid-frame: the current frame completes unchanged; the next state after GAP is IDLE.
REQ-027 sdi[k] = 0 whenever cs_n=1.

Reset
REQ-028 When reset_n=0 at a fclk edge: state=IDLE, sclk=0, cs_n=1, sdi=0, s_axis_tready=0, frame_done=0, underrun=0, held sample=0, dividers cleared.
REQ-029 Reset mid-frame aborts immediately without a frame_done pulse; the first frame after release starts from LOAD with full timing.

Configuration
REQ-030 Macro DAC_SERIAL_OFFSET_BIN_EN defined: the MSB of each channel sample is inverted at capture in LOAD (two's complement to offset binary for unipolar DACs); held sample stores the converted value.
REQ-031 Macro DAC_SERIAL_OFFSET_BIN_EN undefined: samples are shifted out unmodified.

Verification (defaults DW=16, NCH=2, CLK_DIV=1, FRAME_CYC=24)
REQ-032 tdata ch0=0xA5F0, ch1=0x1234, tvalid held 1, en=1 -> a capture model (sample sdi on sclk rise, latch on cs_n rise) reads 0xA5F0/0x1234; cs_n low for 32 cycles; LOAD-to-LOAD spacing is 48 cycles.
REQ-033 tvalid=0 at second LOAD -> underrun pulse in that cycle; frame repeats 0xA5F0/0x1234; frame_done still pulses.
REQ-034 With DAC_SERIAL_OFFSET_BIN_EN defined, ch0=0x8000, ch1=0x7FFF -> captured 0x0000/0xFFFF; with the macro undefined, captured 0x8000/0x7FFF.
REQ-035 reset_n=0 for 1 cycle at bit 7 of a frame -> next cycle cs_n=1, sclk=0, sdi=0, no frame_done; next frame is complete and correct.
REQ-036 en dropped at bit 3 -> all 16 bits are shifted, frame_done pulses, state returns to IDLE, and no further tready occurs; CLK_DIV=3 rerun gives a 144-cycle frame period.

Source files
------------

// File: rtl/dac_serial_stream.sv
// Multi-channel serial DAC streamer: one sample vector per frame, shifted MSB first
// on shared sclk/cs_n. Define DAC_SERIAL_OFFSET_BIN_EN to convert samples to offset binary.
module dac_serial_stream #(
  parameter int DW        = 16,
  parameter int NCH       = 2,
  parameter int CLK_DIV   = 1,
  parameter int FRAME_CYC = 24
) (
  input  logic              fclk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  output logic              sclk,
  output logic [NCH-1:0]    sdi,
  output logic              cs_n,
  output logic              frame_done,
  output logic              underrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // GAP starts with the frame_done cycle, so LOAD + SHIFT + GAP spans FRAME_CYC sclk periods.
  localparam int GAP_CYC = (FRAME_CYC - DW) * 2 * CLK_DIV - 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(DW);
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  logic [1:0]                state_q;
  logic [DIV_W-1:0]          div_q;
  logic [BIT_W-1:0]          bit_q;
  logic [GAP_W-1:0]          gap_q;
  logic [NCH-1:0][DW-1:0]    sh_q;
  logic [NCH-1:0][DW-1:0]    held_q;
  logic [NCH-1:0][DW-1:0]    in_vec;
  logic [NCH-1:0][DW-1:0]    load_vec;
  logic [NCH-1:0][DW-1:0]    sh_next;
  logic [NCH-1:0]            load_msb;
  logic [NCH-1:0]            next_msb;

  assign in_vec = s_axis_tdata;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    load_vec = held_q;
    if (s_axis_tvalid) begin
      for (int k = 0; k < NCH; k++) begin
        load_vec[k] = in_vec[k];
`ifdef DAC_SERIAL_OFFSET_BIN_EN
        load_vec[k][DW-1] = ~in_vec[k][DW-1];
`endif
      end
    end
  end

  always_comb begin
    sh_next  = '0;
    load_msb = '0;
    next_msb = '0;
    for (int k = 0; k < NCH; k++) begin
      sh_next[k]  = {sh_q[k][DW-2:0], 1'b0};
      load_msb[k] = load_vec[k][DW-1];
      next_msb[k] = sh_q[k][DW-2];
    end
  end

  // Handshake and underrun are pure decodes of the LOAD state, valid in the same cycle.
  assign s_axis_tready = (state_q == S_LOAD);
  assign underrun      = (state_q == S_LOAD) && !s_axis_tvalid;

  // NOTE: sequential state uses non-blocking assignments only; the shift and held registers
  // are small, so they are cleared in reset like the rest of the datapath.
  always_ff @(posedge fclk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sh_q       <= '0;
      held_q     <= '0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      sdi        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) state_q <= S_LOAD;
        end
        S_LOAD: begin
          held_q  <= load_vec;
          sh_q    <= load_vec;
          sdi     <= load_msb;
          cs_n    <= 1'b0;
          sclk    <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_q == BIT_LAST) begin
              sclk       <= 1'b0;
              cs_n       <= 1'b1;
              sdi        <= '0;
              frame_done <= 1'b1;
              gap_q      <= '0;
              state_q    <= S_GAP;
            end else begin
              // Falling sclk opens the next bit period and moves the data.
              sclk  <= 1'b0;
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_next;
              sdi   <= next_msb;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= en ? S_LOAD : S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_stream.sv
// Self-checking bench for dac_serial_stream: a DAC-side capture model and a sample-hold
// reference model; a second instance with CLK_DIV=3 checks the stretched frame period.
module tb_dac_serial_stream;
  localparam int DW      = 16;
  localparam int NCH     = 2;
  localparam int PERIOD1 = 24 * 2 * 1;
  localparam int PERIOD3 = 24 * 2 * 3;

  logic              fclk          = 1'b0;
  logic              reset_n       = 1'b0;
  logic              en            = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic [NCH*DW-1:0] s_axis_tdata  = '0;
  logic              s_axis_tready, sclk, cs_n, frame_done, underrun;
  logic [NCH-1:0]    sdi;
  logic              tready3, sclk3, cs_n3, frame_done3, underrun3;
  logic [NCH-1:0]    sdi3;

  always #5 fclk = ~fclk;

  dac_serial_stream dut (
    .fclk(fclk), .reset_n(reset_n), .en(en), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .sclk(sclk),
    .sdi(sdi), .cs_n(cs_n), .frame_done(frame_done), .underrun(underrun)
  );

  dac_serial_stream #(.CLK_DIV(3)) dut3 (
    .fclk(fclk), .reset_n(reset_n), .en(en), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(tready3), .s_axis_tdata(s_axis_tdata), .sclk(sclk3),
    .sdi(sdi3), .cs_n(cs_n3), .frame_done(frame_done3), .underrun(underrun3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] v);
`ifdef DAC_SERIAL_OFFSET_BIN_EN
    return v ^ 16'h8000;
`else
    return v;
`endif
  endfunction

  typedef struct {
    int   cyc;
    logic und;
  } load_t;

  typedef struct {
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    int            nbits;
    int            cs_low;
    logic          fd;
  } cap_t;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          valid;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  load_t load_q[$];
  int    load3_q[$];
  cap_t  cap_q[$];

  // DAC-side capture model: sample sdi on sclk rise while selected, latch on cs_n rise.
  int            cyc       = 0;
  int            bad       = 0;
  int            live_bits = 0;
  int            cs_low    = 0;
  logic          prev_sclk = 1'b0;
  logic          prev_cs   = 1'b1;
  logic [DW-1:0] m0        = '0;
  logic [DW-1:0] m1        = '0;

  always @(negedge fclk) begin
    load_t ev;
    cap_t  cp;
    cyc++;
    if (s_axis_tready) begin
      ev.cyc = cyc;
      ev.und = underrun;
      load_q.push_back(ev);
    end
    if (underrun && !s_axis_tready) bad++;
    if (tready3) load3_q.push_back(cyc);
    if (prev_cs && !cs_n) begin
      m0 = '0; m1 = '0; live_bits = 0; cs_low = 0;
    end
    if (!cs_n) cs_low++;
    if (!cs_n && !prev_sclk && sclk) begin
      m0 = {m0[DW-2:0], sdi[0]};
      m1 = {m1[DW-2:0], sdi[1]};
      live_bits++;
    end
    if (!prev_cs && cs_n) begin
      cp.c0 = m0; cp.c1 = m1; cp.nbits = live_bits; cp.cs_low = cs_low; cp.fd = frame_done;
      cap_q.push_back(cp);
    end else if (frame_done) begin
      bad++;
    end
    if (cs_n && (sdi != '0 || sclk)) bad++;
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  int               prev_load = 0;
  bit               have_prev = 1'b0;
  logic [2*DW-1:0]  model_held = '0;

  task automatic wait_load(output load_t ev, output bit ok);
    ok = 1'b0;
    ev.cyc = 0;
    ev.und = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (load_q.size() > 0) begin
        ev = load_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge fclk);
    end
  endtask

  task automatic wait_cap(output cap_t cp, output bit ok);
    ok = 1'b0;
    cp.c0 = '0; cp.c1 = '0; cp.nbits = 0; cp.cs_low = 0; cp.fd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cap_q.size() > 0) begin
        cp = cap_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge fclk);
    end
  endtask

  task automatic wait_bits(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (live_bits >= n && !cs_n) begin
        ok = 1'b1;
        return;
      end
      @(negedge fclk);
    end
  endtask

  // Called at a negedge outside LOAD; drives the sample, then checks the whole frame.
  task automatic run_frame(input string name, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic v, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    load_t ev;
    cap_t  cp;
    bit    ok;
    s_axis_tdata  = {d1, d0};
    s_axis_tvalid = v;
    wait_load(ev, ok);
    check({name, " load_seen"}, ok, 1);
    if (!ok) return;
    check({name, " underrun"}, ev.und, !v);
    if (have_prev) check({name, " period"}, ev.cyc - prev_load, PERIOD1);
    prev_load = ev.cyc;
    have_prev = 1'b1;
    wait_cap(cp, ok);
    check({name, " cap_seen"}, ok, 1);
    if (!ok) return;
    check({name, " data"}, {cp.c1, cp.c0}, {e1, e0});
    check({name, " nbits"}, cp.nbits, DW);
    check({name, " cs_low"}, cp.cs_low, 2 * DW);
    check({name, " frame_done"}, cp.fd, 1);
    model_held = {e1, e0};
  endtask

  vec_t vec[6];

  initial begin
    bit            ok;
    load_t         ev;
    cap_t          cp;
    logic [DW-1:0] r0, r1, x0, x1;
    logic          rv;

    vec[0] = '{16'hA5F0, 16'h1234, 1'b1, conv(16'hA5F0), conv(16'h1234)};
    vec[1] = '{16'hDEAD, 16'hBEEF, 1'b0, conv(16'hA5F0), conv(16'h1234)};
    vec[2] = '{16'h8000, 16'h7FFF, 1'b1, conv(16'h8000), conv(16'h7FFF)};
    vec[3] = '{16'h0000, 16'hFFFF, 1'b1, conv(16'h0000), conv(16'hFFFF)};
    vec[4] = '{16'hFFFF, 16'h0001, 1'b0, conv(16'h0000), conv(16'hFFFF)};
    vec[5] = '{16'h5555, 16'hAAAA, 1'b1, conv(16'h5555), conv(16'hAAAA)};

    // Reset state.
    repeat (3) @(negedge fclk);
    check("rst cs_n", cs_n, 1);
    check("rst sclk", sclk, 0);
    check("rst sdi", sdi, 0);
    check("rst tready", s_axis_tready, 0);
    check("rst frame_done", frame_done, 0);
    check("rst underrun", underrun, 0);
    reset_n = 1'b1;
    load_q.delete(); load3_q.delete(); cap_q.delete();
    bad = 0;

    // Idle with en low: nothing starts.
    repeat (20) @(negedge fclk);
    check("idle no_tready", load_q.size(), 0);
    check("idle cs_n", cs_n, 1);

    // Table-driven back-to-back frames.
    en = 1'b1;
    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vec[i].d0, vec[i].d1,
                                          vec[i].valid, vec[i].e0, vec[i].e1);

    // Randomized frames against the sample-hold model.
    for (int i = 0; i < 10; i++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      x0 = rv ? conv(r0) : model_held[DW-1:0];
      x1 = rv ? conv(r1) : model_held[2*DW-1:DW];
      run_frame($sformatf("rnd%0d", i), r0, r1, rv, x0, x1);
    end

    // Reset at bit 7 aborts the frame without frame_done.
    s_axis_tdata  = {16'hC3C3, 16'h3C3C};
    s_axis_tvalid = 1'b1;
    wait_load(ev, ok);
    check("rstmid load_seen", ok, 1);
    wait_bits(7, ok);
    check("rstmid bit7", ok, 1);
    reset_n = 1'b0;
    @(negedge fclk);
    check("rstmid cs_n", cs_n, 1);
    check("rstmid sclk", sclk, 0);
    check("rstmid sdi", sdi, 0);
    check("rstmid frame_done", frame_done, 0);
    check("rstmid tready", s_axis_tready, 0);
    reset_n    = 1'b1;
    model_held = '0;
    have_prev  = 1'b0;
    wait_cap(cp, ok);
    check("rstmid abort_seen", ok, 1);
    check("rstmid abort_no_fd", cp.fd, 0);
    check("rstmid abort_partial", cp.nbits < DW, 1);
    // Held sample was cleared: an underrun right after reset replays zero.
    run_frame("post_rst_held", 16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0000);
    run_frame("post_rst_full", 16'h0F0F, 16'hF00F, 1'b1, conv(16'h0F0F), conv(16'hF00F));

    // en dropped at bit 3: frame completes, then the block idles.
    s_axis_tdata  = {16'h2468, 16'h1357};
    s_axis_tvalid = 1'b1;
    wait_load(ev, ok);
    check("endrop load_seen", ok, 1);
    check("endrop period", ev.cyc - prev_load, PERIOD1);
    wait_bits(3, ok);
    check("endrop bit3", ok, 1);
    en = 1'b0;
    wait_cap(cp, ok);
    check("endrop cap_seen", ok, 1);
    check("endrop data", {cp.c1, cp.c0}, {conv(16'h2468), conv(16'h1357)});
    check("endrop nbits", cp.nbits, DW);
    check("endrop frame_done", cp.fd, 1);
    repeat (150) @(negedge fclk);
    check("endrop no_tready", load_q.size(), 0);
    check("endrop cs_n", cs_n, 1);

    // CLK_DIV=3 instance: frame period stretches to 144 cycles.
    reset_n = 1'b0;
    en      = 1'b1;
    @(negedge fclk);
    reset_n = 1'b1;
    load3_q.delete();
    for (int i = 0; i < 600 && load3_q.size() < 3; i++) @(negedge fclk);
    check("div3 loads_seen", load3_q.size() >= 3, 1);
    if (load3_q.size() >= 3) begin
      check("div3 period0", load3_q[1] - load3_q[0], PERIOD3);
      check("div3 period1", load3_q[2] - load3_q[1], PERIOD3);
    end
    en = 1'b0;

    check("invariants", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
